// File: rtl/tta_pkg.sv
// Shared field layout, widths and decoded-instruction type for the TTA core.
// Field positions are fixed by the 24-bit instruction encoding.
package tta_pkg;

    localparam int INSTR_W  = 24;
    localparam int REG_W    = 7;
    localparam int LIT_W    = 12;

    localparam int RSV_BIT  = 23;
    localparam int FMT_BIT  = 22;
    localparam int HL_BIT   = 21;
    localparam int DEST_MSB = 18;
    localparam int DEST_LSB = 12;
    localparam int SRC_MSB  = 11;
    localparam int SRC_LSB  = 5;
    localparam int LIT_MSB  = 11;
    localparam int LIT_LSB  = 0;

    localparam logic FMT_MOVE = 1'b0;
    localparam logic FMT_LOAD = 1'b1;

    typedef struct packed {
        logic             valid;
        logic             lit_mv;
        logic [REG_W-1:0] src;
        logic [REG_W-1:0] dest;
        logic             hl;
        logic [LIT_W-1:0] lit;
    } decoded_t;

    // Fields of the unselected format are forced to zero; validity only
    // looks at the reserved bits of the format that was actually selected.
    function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        logic     rsv_ok;
        d        = '0;
        d.lit_mv = instr[FMT_BIT];
        d.dest   = instr[DEST_MSB:DEST_LSB];
        if (instr[FMT_BIT] == FMT_LOAD) begin
            d.hl   = instr[HL_BIT];
            d.lit  = instr[LIT_MSB:LIT_LSB];
            rsv_ok = (instr[20:19] == 2'b00);
        end else begin
            d.src  = instr[SRC_MSB:SRC_LSB];
            rsv_ok = (instr[21:19] == 3'b000) && (instr[4:0] == 5'b00000);
        end
        d.valid = ~instr[RSV_BIT] & rsv_ok;
        return d;
    endfunction

endpackage

// File: rtl/decode_unit.sv
// Single-stage registered instruction decoder: move or 12-bit literal load.
// Every instruction decodes in one cycle with no stall; downstream gates on valid.
module decode_unit
    import tta_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    output logic               valid,
    output logic               lit_mv,
    output logic [REG_W-1:0]   src,
    output logic [REG_W-1:0]   dest,
    output logic               hl,
    output logic [LIT_W-1:0]   lit
);

    decoded_t w_dec;
    decoded_t r_dec;

    always_comb begin
        w_dec = decode_instr(instr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec <= '0;
        end else begin
            r_dec <= w_dec;
        end
    end

    assign valid  = r_dec.valid;
    assign lit_mv = r_dec.lit_mv;
    assign src    = r_dec.src;
    assign dest   = r_dec.dest;
    assign hl     = r_dec.hl;
    assign lit    = r_dec.lit;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit; outputs compared as one packed word
// {valid, lit_mv, src, dest, hl, lit} against hand-computed values.
module tb_decode_unit;

    logic        clk;
    logic        rst;
    logic [23:0] instr;
    logic        valid;
    logic        lit_mv;
    logic [6:0]  src;
    logic [6:0]  dest;
    logic        hl;
    logic [11:0] lit;

    int n_pass;
    int n_total;

    decode_unit dut (
        .clk    (clk),
        .rst    (rst),
        .instr  (instr),
        .valid  (valid),
        .lit_mv (lit_mv),
        .src    (src),
        .dest   (dest),
        .hl     (hl),
        .lit    (lit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [28:0] w_obs;
    assign w_obs = {valid, lit_mv, src, dest, hl, lit};

    task automatic step(input logic r, input logic [23:0] w);
        @(negedge clk);
        rst   = r;
        instr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [28:0] exp_v;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 24'h000000);
            exp_v = '0;
            n_total++;
            if (w_obs !== exp_v) $display("FAIL reset_hold%0d: got %h want %h", i, w_obs, exp_v);
            else n_pass++;
        end
        step(1'b1, 24'h600FFF);
        exp_v = '0;
        n_total++;
        if (w_obs !== exp_v) $display("FAIL reset_nonzero_instr: got %h want %h", w_obs, exp_v);
        else n_pass++;
        step(1'b0, 24'h000000);
        exp_v = {1'b1, 1'b0, 7'h00, 7'h00, 1'b0, 12'h000};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL reset_release: got %h want %h", w_obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_move();
        logic [28:0] exp_v;
        step(1'b0, 24'h07F020);
        exp_v = {1'b1, 1'b0, 7'h01, 7'h7F, 1'b0, 12'h000};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL move: got %h want %h", w_obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_load();
        logic [28:0] exp_v;
        step(1'b0, 24'h600FFF);
        exp_v = {1'b1, 1'b1, 7'h00, 7'h00, 1'b1, 12'hFFF};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL load_high: got %h want %h", w_obs, exp_v);
        else n_pass++;
        step(1'b0, 24'h45A123);
        exp_v = {1'b1, 1'b1, 7'h00, 7'h5A, 1'b0, 12'h123};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL load_low: got %h want %h", w_obs, exp_v);
        else n_pass++;
        // load with reserved bit 19 set: invalid, fields still decoded
        step(1'b0, 24'h48A123);
        exp_v = {1'b0, 1'b1, 7'h00, 7'h0A, 1'b0, 12'h123};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL load_rsv19: got %h want %h", w_obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_invalid();
        logic [28:0] exp_v;
        step(1'b0, 24'h87F020);
        exp_v = {1'b0, 1'b0, 7'h01, 7'h7F, 1'b0, 12'h000};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL inv_bit23: got %h want %h", w_obs, exp_v);
        else n_pass++;
        step(1'b0, 24'h07F021);
        exp_v = {1'b0, 1'b0, 7'h01, 7'h7F, 1'b0, 12'h000};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL inv_move_bit0: got %h want %h", w_obs, exp_v);
        else n_pass++;
        // move with bit 21 set: reserved in move format
        step(1'b0, 24'h27F020);
        exp_v = {1'b0, 1'b0, 7'h01, 7'h7F, 1'b0, 12'h000};
        n_total++;
        if (w_obs !== exp_v) $display("FAIL inv_move_bit21: got %h want %h", w_obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] vin [3];
        logic [28:0] vexp [3];
        logic [28:0] exp_v;
        vin[0]  = 24'h07F020;
        vexp[0] = {1'b1, 1'b0, 7'h01, 7'h7F, 1'b0, 12'h000};
        vin[1]  = 24'h45A123;
        vexp[1] = {1'b1, 1'b1, 7'h00, 7'h5A, 1'b0, 12'h123};
        vin[2]  = 24'h012FE0;
        vexp[2] = {1'b1, 1'b0, 7'h7F, 7'h12, 1'b0, 12'h000};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, vin[i]);
            n_total++;
            if (w_obs !== vexp[i]) $display("FAIL b2b_%0d: got %h want %h", i, w_obs, vexp[i]);
            else n_pass++;
        end
        step(1'b1, 24'h600FFF);
        exp_v = '0;
        n_total++;
        if (w_obs !== exp_v) $display("FAIL reset_midstream: got %h want %h", w_obs, exp_v);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        instr   = 24'h000000;
        test_reset();
        test_move();
        test_load();
        test_invalid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
